// File: rtl/spi_sram_responder.sv
// SPI mode-0 responder emulating a 23LC512-style serial SRAM (READ 0x03 / WRITE 0x02, sequential).
// Define SPI_SRAM_RDSR_EN to add RDSR (0x05) / WRITE-status (0x01) with a mode register.
module spi_sram_responder #(
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              busy,
    output logic              cmd_err,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [7:0]        bd_wdata,
    output logic [7:0]        bd_rdata
);
    // state  | meaning
    // IDLE   | waiting for a synced cs_n fall
    // CMD    | shifting the 8-bit command
    // ADDR   | shifting the 16-bit address
    // READ   | streaming bytes out on SCK falls
    // WRITE  | collecting bytes on SCK rises
    // IGNORE | unsupported command, wait for cs_n high
    localparam int DEPTH = 2**ADDR_W;
    localparam int RX_W  = (ADDR_W > 8) ? ADDR_W : 8;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync, settle;
    logic sck_prev, cs_prev;
    logic sck_s, cs_s, mosi_s, settled, sck_rise, sck_fall, cs_fall;

    state_t state, state_nxt;
    logic [3:0]        bit_cnt, bit_cnt_nxt;
    logic [RX_W-2:0]   shift, shift_nxt;
    logic [RX_W-1:0]   rx;
    logic [7:0]        rx_byte, src;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [7:0]        tx_shift, tx_nxt, rd_byte;
    logic              is_wr, is_wr_nxt, miso_nxt, oe_nxt, err_nxt, mem_we;
    logic [7:0]        mem [DEPTH];
`ifdef SPI_SRAM_RDSR_EN
    logic              sr_op, sr_nxt;
    logic [7:0]        mode_reg, mode_nxt;
`endif

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign settled  = settle[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_fall  = ~cs_s & cs_prev;
    assign busy     = settled & ~cs_s;
    assign rx       = {shift, mosi_s};
    assign rx_byte  = rx[7:0];

    // cs_prev stays low until the synchronizer has flushed, so a cs_n held low
    // through reset never looks like a new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            settle    <= '0;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            settle    <= {settle[SYNC_STAGES-2:0], 1'b1};
            sck_prev  <= sck_s;
            cs_prev   <= settled & cs_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            addr        <= '0;
            tx_shift    <= '0;
            is_wr       <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            cmd_err     <= 1'b0;
            bd_rdata    <= '0;
`ifdef SPI_SRAM_RDSR_EN
            sr_op       <= 1'b0;
            mode_reg    <= 8'h40;
`endif
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift       <= shift_nxt;
            addr        <= addr_nxt;
            tx_shift    <= tx_nxt;
            is_wr       <= is_wr_nxt;
            spi_miso    <= miso_nxt;
            spi_miso_oe <= oe_nxt;
            cmd_err     <= err_nxt;
            bd_rdata    <= mem[bd_addr];
`ifdef SPI_SRAM_RDSR_EN
            sr_op       <= sr_nxt;
            mode_reg    <= mode_nxt;
`endif
        end
    end

    // SPI write takes the port; a simultaneous backdoor write is dropped.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[addr] <= rx_byte;
        else if (bd_we)
            mem[bd_addr] <= bd_wdata;
        rd_byte <= mem[addr];
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        addr_nxt    = addr;
        tx_nxt      = tx_shift;
        is_wr_nxt   = is_wr;
        miso_nxt    = spi_miso;
        oe_nxt      = spi_miso_oe;
        err_nxt     = 1'b0;
        mem_we      = 1'b0;
        src         = rd_byte;
`ifdef SPI_SRAM_RDSR_EN
        sr_nxt      = sr_op;
        mode_nxt    = mode_reg;
        if (sr_op)
            src = mode_reg;
`endif
        if (cs_s) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            miso_nxt    = 1'b0;
            oe_nxt      = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state_nxt   = CMD;
                        bit_cnt_nxt = '0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        shift_nxt   = rx[RX_W-2:0];
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_nxt = '0;
`ifdef SPI_SRAM_RDSR_EN
                            sr_nxt = 1'b0;
`endif
                            case (rx_byte)
                                8'h03: begin state_nxt = ADDR; is_wr_nxt = 1'b0; end
                                8'h02: begin state_nxt = ADDR; is_wr_nxt = 1'b1; end
`ifdef SPI_SRAM_RDSR_EN
                                8'h05: begin state_nxt = READ;  sr_nxt = 1'b1; end
                                8'h01: begin state_nxt = WRITE; sr_nxt = 1'b1; end
`endif
                                default: begin state_nxt = IGNORE; err_nxt = 1'b1; end
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        shift_nxt   = rx[RX_W-2:0];
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            bit_cnt_nxt = '0;
                            addr_nxt    = rx[ADDR_W-1:0];
                            state_nxt   = is_wr ? WRITE : READ;
                        end
                    end
                end
                READ: begin
                    if (sck_fall) begin
                        if (bit_cnt == 4'd0) begin
                            miso_nxt = src[7];
                            tx_nxt   = {src[6:0], 1'b0};
                            oe_nxt   = 1'b1;
                        end else begin
                            miso_nxt = tx_shift[7];
                            tx_nxt   = {tx_shift[6:0], 1'b0};
                        end
                    end
                    if (sck_rise) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_nxt = '0;
`ifdef SPI_SRAM_RDSR_EN
                            if (!sr_op)
                                addr_nxt = addr + ADDR_W'(1);
`else
                            addr_nxt = addr + ADDR_W'(1);
`endif
                        end
                    end
                end
                WRITE: begin
                    if (sck_rise) begin
                        shift_nxt   = rx[RX_W-2:0];
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_nxt = '0;
`ifdef SPI_SRAM_RDSR_EN
                            if (sr_op) begin
                                mode_nxt = rx_byte;
                            end else begin
                                mem_we   = 1'b1;
                                addr_nxt = addr + ADDR_W'(1);
                            end
`else
                            mem_we   = 1'b1;
                            addr_nxt = addr + ADDR_W'(1);
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_sram_responder.sv
// Randomized self-checking bench for spi_sram_responder against a byte-array memory model.
module tb_spi_sram_responder;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst, spi_clk, spi_cs_n, spi_mosi;
    logic       spi_miso, spi_miso_oe, busy, cmd_err;
    logic       bd_we;
    logic [7:0] bd_addr, bd_wdata, bd_rdata;

    int passed = 0;
    int checks = 0;
    logic [7:0] model [256];
    logic [7:0] wbuf [16];
    logic [7:0] rbuf [16];
    int oe_bad;
    int err_cycles;
    int miso_seen;
    logic mon_en = 1'b0;

    spi_sram_responder #(.ADDR_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .busy(busy), .cmd_err(cmd_err),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            if (cmd_err) err_cycles++;
            if (spi_miso) miso_seen++;
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, input logic data_phase,
                        output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            clks(HALF);
            rx[i] = spi_miso;
            if (spi_miso_oe !== data_phase) oe_bad++;
            spi_clk = 1'b1;
            clks(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic frame_start();
        oe_bad   = 0;
        spi_cs_n = 1'b0;
        clks(HALF);
    endtask

    task automatic frame_end();
        clks(HALF);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        clks(8);
    endtask

    task automatic spi_write(input logic [15:0] a, input int n);
        logic [7:0] d;
        frame_start();
        xfer(8'h02, 8, 1'b0, d);
        xfer(a[15:8], 8, 1'b0, d);
        xfer(a[7:0], 8, 1'b0, d);
        for (int i = 0; i < n; i++) begin
            xfer(wbuf[i], 8, 1'b0, d);
            model[8'(a + 16'(i))] = wbuf[i];
        end
        frame_end();
    endtask

    task automatic spi_read(input logic [15:0] a, input int n);
        logic [7:0] d;
        frame_start();
        xfer(8'h03, 8, 1'b0, d);
        xfer(a[15:8], 8, 1'b0, d);
        xfer(a[7:0], 8, 1'b0, d);
        for (int i = 0; i < n; i++) begin
            xfer(8'h00, 8, 1'b1, d);
            rbuf[i] = d;
        end
        frame_end();
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_wdata = d;
        clks(1);
        bd_we = 1'b0;
        model[a] = d;
    endtask

    task automatic bd_read(input logic [7:0] a, output logic [7:0] d);
        bd_addr = a;
        clks(1);
        d = bd_rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1; spi_clk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        bd_we = 1'b0; bd_addr = 8'h00; bd_wdata = 8'h00;
        clks(4);
        checks++; if (spi_miso !== 1'b0)    $display("FAIL reset_miso got=%b exp=0", spi_miso); else passed++;
        checks++; if (spi_miso_oe !== 1'b0) $display("FAIL reset_oe got=%b exp=0", spi_miso_oe); else passed++;
        checks++; if (busy !== 1'b0)        $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        checks++; if (cmd_err !== 1'b0)     $display("FAIL reset_cmd_err got=%b exp=0", cmd_err); else passed++;
        checks++; if (bd_rdata !== 8'h00)   $display("FAIL reset_bd_rdata got=%h exp=00", bd_rdata); else passed++;
        rst = 1'b0;
        clks(5);
        checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy got=%b exp=0", busy); else passed++;
        for (int i = 0; i < 256; i++) bd_write(8'(i), 8'($urandom));
    endtask

    task automatic test_write_backdoor();
        logic [7:0] d;
        wbuf[0] = 8'hA5;
        spi_write(16'h0010, 1);
        bd_read(8'h10, d);
        checks++; if (d !== 8'hA5) $display("FAIL write_bd_read got=%h exp=a5", d); else passed++;
    endtask

    task automatic test_read_preload();
        logic [31:0] w;
        bd_write(8'h20, 8'h11); bd_write(8'h21, 8'h22);
        bd_write(8'h22, 8'h33); bd_write(8'h23, 8'h44);
        spi_read(16'h0020, 4);
        w = {rbuf[0], rbuf[1], rbuf[2], rbuf[3]};
        checks++; if (w !== 32'h11223344) $display("FAIL read_preload got=%h exp=11223344", w); else passed++;
        checks++; if (oe_bad != 0) $display("FAIL read_oe_window got=%0d bad samples exp=0", oe_bad); else passed++;
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        wbuf[0] = 8'hDE; wbuf[1] = 8'hAD;
        spi_write(16'h00FF, 2);
        bd_read(8'hFF, d);
        checks++; if (d !== 8'hDE) $display("FAIL wrap_ff got=%h exp=de", d); else passed++;
        bd_read(8'h00, d);
        checks++; if (d !== 8'hAD) $display("FAIL wrap_00 got=%h exp=ad", d); else passed++;
        spi_read(16'hABFF, 2);
        checks++; if ({rbuf[0], rbuf[1]} !== 16'hDEAD) $display("FAIL wrap_read got=%h exp=dead", {rbuf[0], rbuf[1]}); else passed++;
    endtask

    task automatic test_partial_write();
        logic [7:0] d;
        bd_write(8'h06, 8'h5A);
        frame_start();
        xfer(8'h02, 8, 1'b0, d);
        xfer(8'h00, 8, 1'b0, d);
        xfer(8'h05, 8, 1'b0, d);
        xfer(8'h7E, 8, 1'b0, d);
        xfer(8'hF0, 4, 1'b0, d);
        frame_end();
        model[5] = 8'h7E;
        bd_read(8'h05, d);
        checks++; if (d !== 8'h7E) $display("FAIL partial_full_byte got=%h exp=7e", d); else passed++;
        bd_read(8'h06, d);
        checks++; if (d !== 8'h5A) $display("FAIL partial_discard got=%h exp=5a", d); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL partial_busy got=%b exp=0", busy); else passed++;
    endtask

    task automatic test_bad_cmd(input logic [7:0] cmd);
        logic [7:0] d;
        err_cycles = 0; miso_seen = 0; mon_en = 1'b1;
        frame_start();
        xfer(cmd, 8, 1'b0, d);
        for (int i = 0; i < 3; i++) xfer(8'($urandom), 8, 1'b0, d);
        frame_end();
        mon_en = 1'b0;
        checks++; if (err_cycles != 1) $display("FAIL bad_cmd_%h_err_pulse got=%0d cycles exp=1", cmd, err_cycles); else passed++;
        checks++; if (miso_seen != 0 || oe_bad != 0)
            $display("FAIL bad_cmd_%h_quiet got miso_hi=%0d oe_bad=%0d exp=0/0", cmd, miso_seen, oe_bad); else passed++;
        spi_read(16'h0005, 1);
        checks++; if (rbuf[0] !== 8'h7E) $display("FAIL bad_cmd_%h_next_frame got=%h exp=7e", cmd, rbuf[0]); else passed++;
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d;
        frame_start();
        xfer(8'h03, 8, 1'b0, d);
        xfer(8'h00, 8, 1'b0, d);
        xfer(8'h05, 8, 1'b0, d);
        xfer(8'h00, 3, 1'b1, d);
        rst = 1'b1;
        clks(2);
        checks++; if (spi_miso !== 1'b0 || spi_miso_oe !== 1'b0)
            $display("FAIL midread_reset got miso=%b oe=%b exp=0/0", spi_miso, spi_miso_oe); else passed++;
        rst = 1'b0;
        oe_bad = 0; miso_seen = 0; mon_en = 1'b1;
        for (int i = 0; i < 3; i++) xfer(8'hFF, 8, 1'b0, d);
        mon_en = 1'b0;
        checks++; if (oe_bad != 0 || miso_seen != 0)
            $display("FAIL midread_no_resync got oe_bad=%0d miso_hi=%0d exp=0/0", oe_bad, miso_seen); else passed++;
        frame_end();
        bd_read(8'h05, d);
        checks++; if (d !== 8'h7E) $display("FAIL midread_mem_kept got=%h exp=7e", d); else passed++;
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [7:0]  d;
        int n;
        for (int it = 0; it < 24; it++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    n = $urandom_range(1, 4);
                    for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                    spi_write(a, n);
                end
                1: begin
                    n = $urandom_range(1, 5);
                    spi_read(a, n);
                    for (int i = 0; i < n; i++) begin
                        checks++;
                        if (rbuf[i] !== model[8'(a + 16'(i))])
                            $display("FAIL rand_read a=%h+%0d got=%h exp=%h", a, i, rbuf[i], model[8'(a + 16'(i))]);
                        else passed++;
                    end
                end
                default: begin
                    bd_read(a[7:0], d);
                    checks++;
                    if (d !== model[a[7:0]]) $display("FAIL rand_bd_read a=%h got=%h exp=%h", a[7:0], d, model[a[7:0]]);
                    else passed++;
                end
            endcase
        end
    endtask

`ifdef SPI_SRAM_RDSR_EN
    task automatic test_rdsr();
        logic [7:0] d0, d1;
        frame_start();
        xfer(8'h05, 8, 1'b0, d0);
        xfer(8'h00, 8, 1'b1, d0);
        xfer(8'h00, 8, 1'b1, d1);
        frame_end();
        checks++; if ({d0, d1} !== 16'h4040) $display("FAIL rdsr got=%h exp=4040", {d0, d1}); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_write_backdoor();
        test_read_preload();
        test_wrap();
        test_partial_write();
        test_bad_cmd(8'h9F);
`ifdef SPI_SRAM_RDSR_EN
        test_rdsr();
`else
        test_bad_cmd(8'h05);
`endif
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/spi_sram_responder.md
Name: spi_sram_responder

Overview:
- Synthesizable SPI responder emulating a 23LC512-style serial SRAM: READ 0x03 and WRITE 0x02, 16-bit address, sequential mode.
- Backed by an internal byte array.
- Serves as the far end of the SPI memory master. Used for FPGA emulation and as a bench memory model.
- All SPI inputs are oversampled in the system clock domain. A side-band port lets the bench preload and inspect memory.

Parameters:
- ADDR_W, 8: implemented address bits. DEPTH = 2**ADDR_W bytes; upper received address bits are ignored (aliasing).
- SYNC_STAGES, 2: synchronizer flops on spi_clk, spi_cs_n and spi_mosi (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- spi_clk  in  1  SPI clock, mode 0, at most f_clk/8
- spi_cs_n  in  1  chip select, active low
- spi_mosi  in  1  serial data in, MSB first
- spi_miso  out  1  serial data out, MSB first; 0 when not driving
- spi_miso_oe  out  1  high while the read data phase is active
- busy  out  1  high while cs_n is asserted (synchronized)
- cmd_err  out  1  one-cycle pulse when an unsupported command byte is received
- bd_we  in  1  backdoor write strobe
- bd_addr  in  ADDR_W  backdoor address
- bd_wdata  in  8  backdoor write data
- bd_rdata  out  8  backdoor read data, registered, 1-cycle latency

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset state:
  - state=IDLE, bit_cnt=0, spi_miso=0, spi_miso_oe=0, busy=0, cmd_err=0, bd_rdata=0.
  - Memory array is NOT cleared, matching SRAM behaviour.
- Synchronization and edge detection:
  - Inputs pass through SYNC_STAGES flops.
  - SCK rise is detected as synced sck=1 with previous=0; fall is the inverse.
  - MOSI is sampled on the synchronized rise.
  - Total input-to-edge latency is SYNC_STAGES+1 cycles.
- States: IDLE, CMD, ADDR, READ, WRITE, IGNORE.
  - IDLE: on synced cs_n falling → CMD, bit_cnt=0.
  - CMD: shift 8 bits on SCK rises. On the 8th rise:
    - 0x03 → ADDR (read)
    - 0x02 → ADDR (write)
    - anything else → IGNORE, with a cmd_err pulse
  - ADDR: shift 16 bits. On the 16th rise, latch addr = received[ADDR_W-1:0] and go to READ or WRITE.
  - READ:
    - Memory read is registered: rd_byte = mem[addr], valid 1 cycle after addr changes.
    - On each SCK fall with bit_cnt==0, load tx_shift with rd_byte, drive bit7, set spi_miso_oe=1.
    - Subsequent falls shift the next bit out.
    - On the 8th rise of each byte: addr = addr+1 mod DEPTH, bit_cnt=0.
  - WRITE:
    - Shift 8 bits on rises.
    - On the 8th rise: mem[addr] = byte, then addr = addr+1 mod DEPTH.
  - IGNORE: no response until cs_n deasserts.
- CS deassert (synced cs_n high) in any state → IDLE next cycle.
  - spi_miso=0, spi_miso_oe=0.
  - A partially received write byte is discarded; completed bytes remain written.
- Wrap-around: address DEPTH-1 increments to 0 for both reads and writes.
- Simultaneous events:
  - SPI write and bd_we in the same cycle: the SPI write wins; the backdoor write is dropped.
  - Backdoor read is always serviced.
- busy mirrors inverted synced cs_n.
- Reset asserted mid-frame: IDLE immediately. After reset, a new frame is recognized only after a synced cs_n fall.
- Read data reflects SPI writes made earlier in the same or previous frames; there is no write buffering.

Optional Feature:
- Macro SPI_SRAM_RDSR_EN.
  - Defined:
    - Command 0x05 (RDSR) returns an 8-bit mode register MSB first, repeated while CS stays low.
    - Command 0x01 (WRSR) writes the mode register.
    - The mode register resets to 0x40 (sequential mode), and its value does not alter addressing.
  - Undefined: 0x05 and 0x01 are treated as unsupported: cmd_err pulse, then IGNORE.

Test Plan:
- Write 0x02, addr 0x0010, data A5 → deassert CS; bd_addr=0x10 → bd_rdata=0xA5 one cycle later.
- bd_we preload mem[0x20..0x23]=11,22,33,44; SPI 0x03 addr 0x0020, 32 SCKs → MISO returns 0x11223344, spi_miso_oe=1 during data only.
- Write 0x02 addr 0x00FF, bytes DE AD → mem[0xFF]=0xDE, mem[0x00]=0xAD (wrap, ADDR_W=8).
- Write 0x02 addr 0x0005, 1 full byte 0x7E then 4 bits of 0xF0 and CS high → mem[5]=0x7E, mem[6] unchanged, state IDLE.
- Command 0x9F → cmd_err one-cycle pulse, MISO stays 0; the next frame 0x03 addr 0x0005 returns 0x7E.
- Reset mid-read → spi_miso=0, spi_miso_oe=0, state IDLE; memory retains 0x7E at addr 5.
